// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared constants, size/state encodings and alignment helper
package mem_access_ctrl_pkg;

    localparam int WORD_BITS = 64;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RESP,
        WR,
        RMW_RD,
        RMW_WR
    } state_e;

    // Natural alignment: the byte offset must be a multiple of the access size.
    function automatic logic is_misaligned(size_e size, logic [2:0] offset);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = offset[0];
            SZ_WORD: is_misaligned = |offset[1:0];
            default: is_misaligned = |offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian byte-lane extract/extend for loads and lane merge for stores
//
// Ports:
//   size      access size (size_e encoding)
//   sign_ext  sign-extend sub-dword loads from their top bit
//   offset    byte offset inside the doubleword
//   ram_rdata doubleword read from RAM
//   st_data   store data, low bytes significant
//   ld_data   aligned, extended load result
//   merged    ram_rdata with the addressed lanes replaced by store bytes
module mem_lane_align
    import mem_access_ctrl_pkg::*;
#(
    parameter int WORD = WORD_BITS
) (
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [2:0]      offset,
    input  logic [WORD-1:0] ram_rdata,
    input  logic [WORD-1:0] st_data,
    output logic [WORD-1:0] ld_data,
    output logic [WORD-1:0] merged
);

    localparam int LANES = WORD / 8;

    logic [WORD-1:0]  shifted;
    logic [WORD-1:0]  st_shifted;
    logic [7:0]       lane_base;
    logic [LANES-1:0] lane_mask;

    always_comb begin
        shifted    = ram_rdata >> {offset, 3'b000};
        st_shifted = st_data << {offset, 3'b000};
        case (size_e'(size))
            SZ_BYTE: begin
                ld_data   = {{(WORD-8){sign_ext & shifted[7]}}, shifted[7:0]};
                lane_base = 8'h01;
            end
            SZ_HALF: begin
                ld_data   = {{(WORD-16){sign_ext & shifted[15]}}, shifted[15:0]};
                lane_base = 8'h03;
            end
            SZ_WORD: begin
                ld_data   = {{(WORD-32){sign_ext & shifted[31]}}, shifted[31:0]};
                lane_base = 8'h0F;
            end
            default: begin
                ld_data   = shifted;
                lane_base = 8'hFF;
            end
        endcase
        lane_mask = LANES'(lane_base) << offset;
        merged    = ram_rdata;
        for (int i = 0; i < LANES; i++) begin
            if (lane_mask[i]) begin
                merged[i*8 +: 8] = st_shifted[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - arbitrates instruction fetch and data access onto one synchronous RAM port
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   if_req/if_addr                  fetch request and byte address
//   if_ack/if_rdata/if_err          fetch done pulse, instruction, misaligned flag
//   d_req/d_we/d_size/d_signed      data request, store, size, sign-extend load
//   d_addr/d_wdata                  data byte address and store data
//   d_ack/d_rdata/d_err             data done pulse, load result, misaligned flag
//   ram_addr/ram_re/ram_we          doubleword index, read and write strobes
//   ram_wdata/ram_rdata             write data, read data (valid the cycle after ram_re)
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int WORD   = WORD_BITS,
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [WORD-1:0]   if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [WORD-1:0]   d_addr,
    input  logic [WORD-1:0]   d_wdata,
    output logic              d_ack,
    output logic [WORD-1:0]   d_rdata,
    output logic              d_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [WORD-1:0]   ram_wdata,
    input  logic [WORD-1:0]   ram_rdata
);

    localparam int AW = RAM_AW + 3;

    state_e          state;
    logic            last_grant_fetch;
    logic            cap_fetch;
    logic            cap_we;
    logic            cap_signed;
    size_e           cap_size;
    logic [AW-1:0]   cap_addr;
    logic [WORD-1:0] cap_wdata;

    logic            grant_if;
    logic            grant_d;
    logic [AW-1:0]   sel_addr;
    size_e           sel_size;
    logic            sel_mis;
    logic [WORD-1:0] ld_data;
    logic [WORD-1:0] merged;
    logic            unused_addr_hi;

    // Address bits above the RAM window are ignored.
    assign unused_addr_hi = ^{if_addr[WORD-1:AW], d_addr[WORD-1:AW]};

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE) begin
            if (if_req && d_req) begin
                grant_if = !last_grant_fetch;
                grant_d  = last_grant_fetch;
            end else begin
                grant_if = if_req;
                grant_d  = d_req;
            end
        end
    end

    assign sel_addr = grant_if ? if_addr[AW-1:0] : d_addr[AW-1:0];
    assign sel_size = grant_if ? SZ_WORD : size_e'(d_size);
    assign sel_mis  = is_misaligned(sel_size, sel_addr[2:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            last_grant_fetch <= 1'b1;
            cap_fetch        <= 1'b0;
            cap_we           <= 1'b0;
            cap_signed       <= 1'b0;
            cap_size         <= SZ_BYTE;
            cap_addr         <= '0;
            cap_wdata        <= '0;
            ram_re           <= 1'b0;
            ram_we           <= 1'b0;
            if_ack           <= 1'b0;
            if_err           <= 1'b0;
            d_ack            <= 1'b0;
            d_err            <= 1'b0;
        end else begin
            ram_re <= 1'b0;
            ram_we <= 1'b0;
            if_ack <= 1'b0;
            if_err <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if || grant_d) begin
                        last_grant_fetch <= grant_if;
                        cap_fetch        <= grant_if;
                        cap_we           <= grant_d & d_we;
                        cap_signed       <= grant_d & d_signed;
                        cap_size         <= sel_size;
                        cap_addr         <= sel_addr;
                        cap_wdata        <= grant_d ? d_wdata : '0;
                        if (sel_mis) begin
                            state  <= RESP;
                            if_ack <= grant_if;
                            if_err <= grant_if;
                            d_ack  <= grant_d;
                            d_err  <= grant_d;
                        end else if (grant_if || !d_we) begin
                            state  <= RD;
                            ram_re <= 1'b1;
                        end else if (sel_size == SZ_DWORD) begin
                            state  <= WR;
                            ram_we <= 1'b1;
                            d_ack  <= 1'b1;
                        end else begin
                            state  <= RMW_RD;
                            ram_re <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state  <= RESP;
                    if_ack <= cap_fetch;
                    d_ack  <= !cap_fetch;
                end
                RMW_RD: begin
                    state  <= RMW_WR;
                    ram_we <= 1'b1;
                    d_ack  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_lane_align #(.WORD(WORD)) u_lane_align (
        .size      (cap_size),
        .sign_ext  (cap_signed),
        .offset    (cap_addr[2:0]),
        .ram_rdata (ram_rdata),
        .st_data   (cap_wdata),
        .ld_data   (ld_data),
        .merged    (merged)
    );

    // A full-lane merge reduces to the store data, so WR and RMW_WR share the path.
    assign ram_addr  = cap_addr[AW-1:3];
    assign ram_wdata = ram_we ? merged : '0;
    assign d_rdata   = (d_ack && !d_err && !cap_we) ? ld_data : '0;
    assign if_rdata  = (if_ack && !if_err) ? (cap_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0]) : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl with a byte-array reference model
module tb_mem_access_ctrl;

    localparam int WORD   = 64;
    localparam int RAM_AW = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [WORD-1:0]   if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              if_err;
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_signed;
    logic [WORD-1:0]   d_addr;
    logic [WORD-1:0]   d_wdata;
    logic              d_ack;
    logic [WORD-1:0]   d_rdata;
    logic              d_err;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_re;
    logic              ram_we;
    logic [WORD-1:0]   ram_wdata;
    logic [WORD-1:0]   ram_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.WORD(WORD), .RAM_AW(RAM_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_signed  (d_signed),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    logic [63:0] mem [0:1023];
    logic [7:0]  ref_mem [0:8191];

    always @(posedge clk) begin
        if (ram_re) ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    int vectors     = 0;
    int miscompares = 0;
    int re_cnt      = 0;
    int we_cnt      = 0;
    bit excl_viol   = 1'b0;

    always @(negedge clk) begin
        if (ram_re) re_cnt++;
        if (ram_we) we_cnt++;
        if (ram_re && ram_we) excl_viol = 1'b1;
        if (if_ack && d_ack) excl_viol = 1'b1;
        if (!d_ack && d_rdata != 0) excl_viol = 1'b1;
        if (!if_ack && if_rdata != 0) excl_viol = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [1:0] sz, input logic sg);
        logic [63:0] v;
        logic [12:0] idx;
        int n;
        v = '0;
        n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            idx = addr[12:0] + 13'(i);
            v[8*i +: 8] = ref_mem[idx];
        end
        if (sg && sz != 2'd3 && v[8*n-1]) begin
            for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] addr, input logic [1:0] sz, input logic [63:0] wd);
        logic [12:0] idx;
        for (int i = 0; i < (1 << sz); i++) begin
            idx = addr[12:0] + 13'(i);
            ref_mem[idx] = wd[8*i +: 8];
        end
    endtask

    task automatic data_op(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                           input logic [63:0] addr, input logic [63:0] wd, output logic [63:0] rd);
        logic        mis;
        int          exp_lat;
        int          lat;
        logic [63:0] exp_rd;
        int          re0;
        int          we0;
        bit          got;
        mis     = (int'(addr[2:0]) % (1 << sz)) != 0;
        exp_lat = (mis || (we && sz == 2'd3)) ? 1 : 2;
        exp_rd  = (mis || we) ? 64'd0 : ref_load(addr, sz, sg);
        re0 = re_cnt;
        we0 = we_cnt;
        d_we = we; d_size = sz; d_signed = sg; d_addr = addr; d_wdata = wd; d_req = 1'b1;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (d_ack) begin
                got = 1'b1;
                lat = c;
                rd  = d_rdata;
            end
        end
        chk({tag, ":ack"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, ":lat"}, 64'(lat), 64'(exp_lat));
            chk({tag, ":err"}, 64'(d_err), 64'(mis));
            if (!we) chk({tag, ":rdata"}, d_rdata, exp_rd);
            if (mis) chk({tag, ":ram_traffic"}, 64'((re_cnt - re0) + (we_cnt - we0)), 64'd0);
        end
        @(posedge clk);
        #1 d_req = 1'b0;
        if (we && !mis) ref_store(addr, sz, wd);
    endtask

    task automatic fetch_op(input string tag, input logic [63:0] addr);
        logic        mis;
        logic [63:0] full;
        logic [31:0] exp_rd;
        int          lat;
        bit          got;
        mis    = addr[1:0] != 2'b00;
        full   = ref_load(addr, 2'd2, 1'b0);
        exp_rd = mis ? 32'd0 : full[31:0];
        if_addr = addr;
        if_req  = 1'b1;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_ack) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk({tag, ":ack"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, ":lat"}, 64'(lat), mis ? 64'd1 : 64'd2);
            chk({tag, ":err"}, 64'(if_err), 64'(mis));
            chk({tag, ":rdata"}, 64'(if_rdata), 64'(exp_rd));
        end
        @(posedge clk);
        #1 if_req = 1'b0;
    endtask

    logic [63:0] rd;
    string       order;
    int          cyc;
    int          we0;

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 64'({ram_re, ram_we, if_ack, d_ack, if_err, d_err}), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wdata", ram_wdata, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // dword store then load
        data_op("st_dw", 1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, rd);
        chk("st_dw:mem", mem[2], 64'h1122334455667788);
        data_op("ld_dw", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, rd);
        chk("ld_dw:const", rd, 64'h1122334455667788);

        // byte store into the middle of that doubleword, signed/unsigned reload
        data_op("sturb", 1'b1, 2'd0, 1'b0, 64'h13, 64'hAB, rd);
        chk("sturb:mem", mem[2], 64'h11223344AB667788);
        data_op("ldurb_s", 1'b0, 2'd0, 1'b1, 64'h13, 64'd0, rd);
        chk("ldurb_s:const", rd, 64'hFFFFFFFFFFFFFFAB);
        data_op("ldurb_u", 1'b0, 2'd0, 1'b0, 64'h13, 64'd0, rd);
        chk("ldurb_u:const", rd, 64'h00000000000000AB);

        // misaligned half load
        data_op("ld_h_mis", 1'b0, 2'd1, 1'b0, 64'h11, 64'd0, rd);

        // reset while a byte store sits in its read phase
        d_we = 1'b1; d_size = 2'd0; d_signed = 1'b0; d_addr = 64'h13; d_wdata = 64'hCD; d_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort:rmw_read", 64'(ram_re), 64'd1);
        we0 = we_cnt;
        reset = 1'b1;
        @(posedge clk);
        #1 d_req = 1'b0;
        @(negedge clk);
        chk("abort:outputs", 64'({ram_we, ram_re, d_ack, d_err}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort:no_write", 64'(we_cnt - we0), 64'd0);
        chk("abort:mem", mem[2], 64'h11223344AB667788);
        data_op("abort:reload", 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, rd);

        // both requesters held from reset: data wins first, then alternation
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        if_addr = 64'h14; if_req = 1'b1;
        d_we = 1'b0; d_size = 2'd3; d_signed = 1'b0; d_addr = 64'h10; d_req = 1'b1;
        order = "";
        cyc = 0;
        while (order.len() < 4 && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (d_ack) begin
                order = {order, "D"};
                chk("arb:d_rdata", d_rdata, ref_load(64'h10, 2'd3, 1'b0));
            end
            if (if_ack) begin
                order = {order, "F"};
                chk("arb:if_rdata", 64'(if_rdata), 64'h11223344);
            end
        end
        @(posedge clk);
        #1 if_req = 1'b0; d_req = 1'b0;
        chk("arb:order", 64'(order == "DFDF"), 64'd1);
        if (order != "DFDF") $display("  grant order seen: %s", order);

        // random mix over a small window so loads hit earlier stores
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                fetch_op("rnd_f", 64'($urandom_range(0, 255)));
            end else begin
                data_op("rnd_d", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 64'($urandom_range(0, 255)),
                        {$urandom, $urandom}, rd);
            end
        end

        chk("exclusivity_and_idle_zero", 64'(excl_viol), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
